instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 18 +
 rtl/instr_loader_if.sv | 19 +
 rtl/instr_loader_byte_packer.sv | 50 +++++
 rtl/instr_loader.sv | 123 ++++++++++++
 tb/tb_instr_loader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// instr_loader_pkg : shared states and constants for the instruction loader
// Revision: 1.0
// ============================================================================
package instr_loader_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// instr_loader_if : program byte stream in, instruction-memory write port out
// Revision: 1.0
// ============================================================================
interface instr_loader_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic             we;
   logic [WIDTH-1:0] wa;
   logic [31:0]      wd;

   modport master (input in_valid, in_data, output in_ready, we, wa, wd);
   modport slave  (output in_valid, in_data, input in_ready, we, wa, wd);
endinterface
`default_nettype wire

// File: rtl/instr_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// byte_packer : big-endian byte-to-word assembly with word-complete strobe
// Revision: 1.0
// ============================================================================
module byte_packer
   import instr_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_complete_o
);
   localparam int             CW       = $clog2(BYTES_PER_WORD);
   localparam logic [CW-1:0]  LAST_IDX = CW'(BYTES_PER_WORD - 1);

   // Only the three earlier bytes are stored; the final byte is merged in flight.
   logic [23:0]   shreg_q, shreg_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      shreg_d = shreg_q;
      count_d = count_q;
      if (clear_i) begin
         shreg_d = '0;
         count_d = '0;
      end else if (shift_i) begin
         shreg_d = {shreg_q[15:0], byte_i};
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q <= '0;
         count_q <= '0;
      end else begin
         shreg_q <= shreg_d;
         count_q <= count_d;
      end
   end

   assign word_o          = {shreg_q, byte_i};
   assign word_complete_o = shift_i && (count_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// instr_loader : loads n_words big-endian 32-bit words from a byte stream
// Revision: 1.0
// ============================================================================
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2**WIDTH
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH:0]   n_words,
   output logic             busy,
   output logic             done,
   output logic             err,
   instr_loader_if.master   bus
);
   localparam logic [1:0]     ST_IDLE    = IDLE;
   localparam logic [1:0]     ST_COLLECT = COLLECT;
   localparam logic [1:0]     ST_WRITE   = WRITE;
   localparam logic [1:0]     ST_DONE    = DONE;
   localparam logic [WIDTH:0] C_DEPTH    = (WIDTH+1)'(DEPTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH:0]   n_q, n_d;
   logic [WIDTH:0]   addr_q, addr_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] wa_q, wa_d;
   logic [31:0]      wd_q, wd_d;
   logic             err_q, err_d;

   logic             w_load;
   logic             w_accept;
   logic             w_complete;
   logic [31:0]      w_word;

   assign w_load   = (state_q == ST_IDLE) && start && (n_words != '0) && (n_words <= C_DEPTH);
   assign w_accept = bus.in_valid && (state_q == ST_COLLECT);

   byte_packer u_packer (
      .clk             (clk),
      .reset           (reset),
      .clear_i         (w_load),
      .shift_i         (w_accept),
      .byte_i          (bus.in_data),
      .word_o          (w_word),
      .word_complete_o (w_complete)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      wa_d    = wa_q;
      wd_d    = wd_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (n_words > C_DEPTH) begin
                  err_d = 1'b1;
               end else if (n_words == '0) begin
                  err_d   = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  err_d   = 1'b0;
                  n_d     = n_words;
                  addr_d  = '0;
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (w_complete) begin
               we_d    = 1'b1;
               wa_d    = addr_q[WIDTH-1:0];
               wd_d    = w_word;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            addr_d  = addr_q + 1'b1;
            state_d = ((addr_q + 1'b1) == n_q) ? ST_DONE : ST_COLLECT;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready = (state_q == ST_COLLECT);
   assign bus.we       = we_q;
   assign bus.wa       = wa_q;
   assign bus.wd       = wd_q;
   assign busy         = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
   assign done         = (state_q == ST_DONE);
   assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// tb_instr_loader : randomized self-checking bench against a word-list model
// Revision: 1.0
// ============================================================================
module tb_instr_loader;
   localparam int WIDTH = 8;
   localparam int DEPTH = 256;

   logic           clk     = 1'b0;
   logic           reset   = 1'b1;
   logic           start   = 1'b0;
   logic [WIDTH:0] n_words = '0;
   logic           busy, done, err;

   instr_loader_if #(.WIDTH(WIDTH)) bus ();

   instr_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .n_words (n_words),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int test_cnt = 0;
   int fail_cnt = 0;

   // Observed memory writes and done pulses, sampled mid-cycle.
   int               cyc = 0;
   logic [WIDTH-1:0] obs_wa[$];
   logic [31:0]      obs_wd[$];
   int               obs_cyc[$];
   int               done_cnt = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         obs_wa.push_back(bus.wa);
         obs_wd.push_back(bus.wd);
         obs_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cnt++;
   end

   // Reference program: word i must land at address i.
   logic [31:0] exp_wd[$];
   logic [7:0]  stim[$];

   task automatic build_stim();
      stim.delete();
      foreach (exp_wd[i])
         for (int b = 3; b >= 0; b--) stim.push_back(exp_wd[i][8*b +: 8]);
   endtask

   task automatic do_start(input int n);
      @(negedge clk);
      start   = 1'b1;
      n_words = (WIDTH+1)'(n);
      @(negedge clk);
      start   = 1'b0;
   endtask

   // alt=1: valid every other cycle; otherwise gap_pct% chance of an idle cycle.
   task automatic send_stream(input bit alt, input int gap_pct, input int poke_idx, output bit ok);
      int idx   = 0;
      int guard = 0;
      bit acc;
      ok = 1'b1;
      while (idx < stim.size()) begin
         if (guard > 20*stim.size() + 50) begin
            ok = 1'b0;
            break;
         end
         if ((alt && (guard % 2 == 1)) || (!alt && ($urandom_range(99) < gap_pct))) begin
            bus.in_valid = 1'b0;
            acc = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim[idx];
            acc = bus.in_ready;
         end
         if (idx == poke_idx) begin
            start   = 1'b1;
            n_words = (WIDTH+1)'(1);
         end else begin
            start = 1'b0;
         end
         guard++;
         @(negedge clk);
         if (acc) idx++;
      end
      bus.in_valid = 1'b0;
      start        = 1'b0;
   endtask

   task automatic finish_load(input bit alt, input int gap_pct, input int poke_idx, output bit ok);
      bit s_ok;
      int d0;
      int guard = 0;
      d0 = done_cnt;
      build_stim();
      send_stream(alt, gap_pct, poke_idx, s_ok);
      #1;
      while (done_cnt == d0 && guard < 40) begin
         @(negedge clk);
         #1;
         guard++;
      end
      ok = s_ok && (done_cnt != d0);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
      test_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done: got %b want 0", done); end
      test_cnt++; if (err !== 1'b0) begin fail_cnt++; $display("FAIL reset_err: got %b want 0", err); end
      test_cnt++; if (bus.in_ready !== 1'b0) begin fail_cnt++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      test_cnt++; if (bus.we !== 1'b0) begin fail_cnt++; $display("FAIL reset_we: got %b want 0", bus.we); end
      test_cnt++; if (bus.wa !== '0) begin fail_cnt++; $display("FAIL reset_wa: got %h want 0", bus.wa); end
      test_cnt++; if (bus.wd !== '0) begin fail_cnt++; $display("FAIL reset_wd: got %h want 0", bus.wd); end
      reset = 1'b0;
   endtask

   task automatic test_full_rate();
      int w0, d0;
      bit ok;
      exp_wd = '{32'h20010003, 32'h20020009};
      w0 = obs_wa.size(); d0 = done_cnt;
      do_start(2);
      finish_load(1'b0, 0, -1, ok);
      test_cnt++; if (!ok) begin fail_cnt++; $display("FAIL full_timeout: load did not finish"); end
      test_cnt++; if (obs_wa.size() - w0 != 2) begin fail_cnt++; $display("FAIL full_count: got %0d writes want 2", obs_wa.size() - w0); end
      for (int i = 0; i < exp_wd.size() && w0 + i < obs_wa.size(); i++) begin
         test_cnt++;
         if (obs_wa[w0+i] !== WIDTH'(i) || obs_wd[w0+i] !== exp_wd[i]) begin
            fail_cnt++;
            $display("FAIL full_write%0d: got wa=%h wd=%h want wa=%h wd=%h", i, obs_wa[w0+i], obs_wd[w0+i], i, exp_wd[i]);
         end
      end
      test_cnt++; if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL full_done: got %0d pulses want 1", done_cnt - d0); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL full_busy: got %b want 0", busy); end
      if (obs_wa.size() - w0 >= 2) begin
         test_cnt++;
         if (obs_cyc[w0+1] - obs_cyc[w0] != 5) begin
            fail_cnt++;
            $display("FAIL full_spacing: got %0d cycles between writes want 5", obs_cyc[w0+1] - obs_cyc[w0]);
         end
      end
   endtask

   task automatic test_half_rate();
      int w0, d0;
      bit ok;
      exp_wd = '{32'h20010003, 32'h20020009};
      w0 = obs_wa.size(); d0 = done_cnt;
      do_start(2);
      finish_load(1'b1, 0, -1, ok);
      test_cnt++; if (!ok) begin fail_cnt++; $display("FAIL half_timeout: load did not finish"); end
      test_cnt++; if (obs_wa.size() - w0 != 2) begin fail_cnt++; $display("FAIL half_count: got %0d writes want 2", obs_wa.size() - w0); end
      for (int i = 0; i < exp_wd.size() && w0 + i < obs_wa.size(); i++) begin
         test_cnt++;
         if (obs_wa[w0+i] !== WIDTH'(i) || obs_wd[w0+i] !== exp_wd[i]) begin
            fail_cnt++;
            $display("FAIL half_write%0d: got wa=%h wd=%h want wa=%h wd=%h", i, obs_wa[w0+i], obs_wd[w0+i], i, exp_wd[i]);
         end
      end
      test_cnt++; if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL half_done: got %0d pulses want 1", done_cnt - d0); end
   endtask

   task automatic test_zero_words();
      int w0, d0;
      w0 = obs_wa.size(); d0 = done_cnt;
      do_start(0);
      test_cnt++; if (done !== 1'b1) begin fail_cnt++; $display("FAIL zero_done_now: got %b want 1", done); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL zero_busy: got %b want 0", busy); end
      @(negedge clk); #1;
      test_cnt++; if (done !== 1'b0) begin fail_cnt++; $display("FAIL zero_done_after: got %b want 0", done); end
      test_cnt++; if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL zero_pulses: got %0d want 1", done_cnt - d0); end
      test_cnt++; if (obs_wa.size() != w0) begin fail_cnt++; $display("FAIL zero_we: got %0d writes want 0", obs_wa.size() - w0); end
   endtask

   task automatic test_too_big();
      int w0, d0;
      bit ok;
      w0 = obs_wa.size(); d0 = done_cnt;
      do_start(DEPTH + 1);
      repeat (3) @(negedge clk);
      #1;
      test_cnt++; if (err !== 1'b1) begin fail_cnt++; $display("FAIL big_err: got %b want 1", err); end
      test_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL big_busy: got %b want 0", busy); end
      test_cnt++; if (obs_wa.size() != w0) begin fail_cnt++; $display("FAIL big_we: got %0d writes want 0", obs_wa.size() - w0); end
      test_cnt++; if (done_cnt != d0) begin fail_cnt++; $display("FAIL big_done: got %0d pulses want 0", done_cnt - d0); end
      exp_wd = '{32'($urandom)};
      do_start(1);
      test_cnt++; if (err !== 1'b0) begin fail_cnt++; $display("FAIL big_err_clear: got %b want 0", err); end
      finish_load(1'b0, 0, -1, ok);
      test_cnt++;
      if (!ok || obs_wa.size() - w0 != 1 || obs_wd[obs_wd.size()-1] !== exp_wd[0]) begin
         fail_cnt++;
         $display("FAIL big_followup: ok=%b writes=%0d want one write of %h", ok, obs_wa.size() - w0, exp_wd[0]);
      end
   endtask

   task automatic test_reset_mid_load();
      int w0, d0;
      bit ok;
      exp_wd = '{32'h11223344};
      w0 = obs_wa.size(); d0 = done_cnt;
      do_start(1);
      stim = '{8'h11, 8'h22};
      send_stream(1'b0, 0, -1, ok);
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h33;
      start        = 1'b1;
      n_words      = (WIDTH+1)'(1);
      repeat (2) @(negedge clk);
      reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk); #1;
      test_cnt++; if (obs_wa.size() != w0) begin fail_cnt++; $display("FAIL rst_mid_we: got %0d writes want 0", obs_wa.size() - w0); end
      test_cnt++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin fail_cnt++; $display("FAIL rst_mid_idle: busy=%b in_ready=%b want 0 0", busy, bus.in_ready); end
      test_cnt++; if (done_cnt != d0) begin fail_cnt++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_cnt - d0); end
      exp_wd = '{32'h00221820};
      do_start(1);
      finish_load(1'b0, 0, -1, ok);
      test_cnt++;
      if (!ok || obs_wa.size() - w0 != 1 || obs_wa[obs_wa.size()-1] !== '0 || obs_wd[obs_wd.size()-1] !== 32'h00221820) begin
         fail_cnt++;
         $display("FAIL rst_mid_reload: ok=%b writes=%0d want one write wa=0 wd=00221820", ok, obs_wa.size() - w0);
      end
   endtask

   task automatic test_start_in_collect();
      int w0, d0;
      bit ok;
      exp_wd = '{32'($urandom), 32'($urandom)};
      w0 = obs_wa.size(); d0 = done_cnt;
      do_start(2);
      finish_load(1'b0, 0, 2, ok);
      test_cnt++; if (!ok) begin fail_cnt++; $display("FAIL poke_timeout: load did not finish"); end
      test_cnt++; if (obs_wa.size() - w0 != 2) begin fail_cnt++; $display("FAIL poke_count: got %0d writes want 2", obs_wa.size() - w0); end
      for (int i = 0; i < exp_wd.size() && w0 + i < obs_wa.size(); i++) begin
         test_cnt++;
         if (obs_wa[w0+i] !== WIDTH'(i) || obs_wd[w0+i] !== exp_wd[i]) begin
            fail_cnt++;
            $display("FAIL poke_write%0d: got wa=%h wd=%h want wa=%h wd=%h", i, obs_wa[w0+i], obs_wd[w0+i], i, exp_wd[i]);
         end
      end
      test_cnt++; if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL poke_done: got %0d pulses want 1", done_cnt - d0); end
   endtask

   // Random programs with random stalls, plus one full-depth load at full rate.
   task automatic test_random_loads();
      int w0, d0, n, gap;
      bit ok;
      for (int it = 0; it < 7; it++) begin
         n   = (it == 6) ? DEPTH : int'($urandom_range(6, 1));
         gap = (it == 6) ? 0 : int'($urandom_range(60, 0));
         exp_wd.delete();
         for (int i = 0; i < n; i++) exp_wd.push_back($urandom);
         w0 = obs_wa.size(); d0 = done_cnt;
         do_start(n);
         finish_load(1'b0, gap, -1, ok);
         test_cnt++; if (!ok) begin fail_cnt++; $display("FAIL rand%0d_timeout: n=%0d did not finish", it, n); end
         test_cnt++; if (obs_wa.size() - w0 != n) begin fail_cnt++; $display("FAIL rand%0d_count: got %0d writes want %0d", it, obs_wa.size() - w0, n); end
         for (int i = 0; i < n && w0 + i < obs_wa.size(); i++) begin
            test_cnt++;
            if (obs_wa[w0+i] !== WIDTH'(i) || obs_wd[w0+i] !== exp_wd[i]) begin
               fail_cnt++;
               $display("FAIL rand%0d_write%0d: got wa=%h wd=%h want wa=%h wd=%h", it, i, obs_wa[w0+i], obs_wd[w0+i], i, exp_wd[i]);
            end
         end
         test_cnt++; if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL rand%0d_done: got %0d pulses want 1", it, done_cnt - d0); end
         test_cnt++; if (busy !== 1'b0 || err !== 1'b0) begin fail_cnt++; $display("FAIL rand%0d_idle: busy=%b err=%b want 0 0", it, busy, err); end
      end
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_half_rate();
      test_zero_words();
      test_too_big();
      test_reset_mid_load();
      test_start_in_collect();
      test_random_loads();
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
